vector_writeback_buffer: RTL

Collects vector-register writeback requests from the vector ALU and the vector memory unit, queues them in a small in-order FIFO, and drains at most one request per cycle into the vector register file write port (write_addr / write_vector / per-lane we). Sits directly upstream of the vector register file. Also reports pending writes to the decoder so it can stall on read-after-write hazards.

---
 rtl/vector_writeback_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vector_writeback_buffer.sv
// rtl/vector_writeback_buffer.sv - in-order writeback FIFO with round-robin ALU/MEM intake and RAW hazard lookup
// Optional zero-latency bypass into the register file write port: define VWB_BYPASS_EN.
module vector_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [31:0]       alu_data [3:0],
    input  logic [3:0]        alu_mask,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data [3:0],
    input  logic [3:0]        mem_mask,
    input  logic              wb_stall,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_vector [3:0],
    output logic [3:0]        we,
    input  logic [ADDR_W-1:0] hz_addr1,
    input  logic [ADDR_W-1:0] hz_addr2,
    output logic              hz_hit1,
    output logic              hz_hit2,
    output logic              busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic PREF_ALU = 1'b0;
    localparam logic PREF_MEM = 1'b1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [31:0]       q_data [DEPTH][4];
    logic [3:0]        q_mask [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              rr_pref;

    logic              space_available;
    logic              grant_alu, grant_mem, grant_any;
    logic              pop, push, bypass;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_data [4];
    logic [3:0]        sel_mask;

    assign pop = (count != '0) && !wb_stall;
    // A full FIFO can still take a request when the head leaves in the same cycle.
    assign space_available = (count < CW'(DEPTH)) || ((count == CW'(DEPTH)) && !wb_stall);

    assign alu_ready = space_available && (!mem_valid || rr_pref == PREF_ALU);
    assign mem_ready = space_available && (!alu_valid || rr_pref == PREF_MEM);
    assign grant_alu = alu_valid && alu_ready;
    assign grant_mem = mem_valid && mem_ready;
    assign grant_any = grant_alu || grant_mem;

    always_comb begin
        sel_addr = grant_mem ? mem_addr : alu_addr;
        sel_mask = grant_mem ? mem_mask : alu_mask;
        for (int l = 0; l < 4; l++) begin
            sel_data[l] = grant_mem ? mem_data[l] : alu_data[l];
        end
    end

`ifdef VWB_BYPASS_EN
    assign bypass = (count == '0) && !wb_stall && grant_any && (sel_mask != 4'h0);
`else
    assign bypass = 1'b0;
`endif

    // Zero-mask requests complete the handshake but never occupy a slot.
    assign push = grant_any && (sel_mask != 4'h0) && !bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_pref <= PREF_ALU;
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= sel_addr;
                q_mask[wr_ptr] <= sel_mask;
                for (int l = 0; l < 4; l++) begin
                    q_data[wr_ptr][l] <= sel_data[l];
                end
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            if (grant_alu) begin
                rr_pref <= PREF_MEM;
            end else if (grant_mem) begin
                rr_pref <= PREF_ALU;
            end
        end
    end

    always_comb begin
        write_addr = '0;
        we         = 4'h0;
        for (int l = 0; l < 4; l++) begin
            write_vector[l] = 32'h0;
        end
        if (pop) begin
            write_addr = q_addr[rd_ptr];
            we         = q_mask[rd_ptr];
            for (int l = 0; l < 4; l++) begin
                write_vector[l] = q_data[rd_ptr][l];
            end
        end else if (bypass) begin
            write_addr = sel_addr;
            we         = sel_mask;
            for (int l = 0; l < 4; l++) begin
                write_vector[l] = sel_data[l];
            end
        end
    end

    // Scan occupied slots from the head; the head counts even while it is being written.
    always_comb begin
        logic [PW-1:0] idx;
        hz_hit1 = bypass && (sel_addr == hz_addr1);
        hz_hit2 = bypass && (sel_addr == hz_addr2);
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_addr[idx] == hz_addr1) hz_hit1 = 1'b1;
                if (q_addr[idx] == hz_addr2) hz_hit2 = 1'b1;
            end
        end
    end

    assign busy = (count != '0);

endmodule
